de_hazard_ctrl: RTL and testbench

Pipeline hazard and flush controller that produces the stall, bubble and flush-count controls consumed by the decode/execute pipeline buffer.
- Watches the decode-stage source registers against the instruction currently in execute (load-use hazard).
- Watches execute-stage branch resolution and the memory-stage busy indication.
- Drives PC/fetch-decode hold, decode/execute bubble insertion and the 2-bit FlashNum flush countdown that rides down the pipeline.

---
 rtl/de_hazard_ctrl_pkg.sv | 19 +
 rtl/de_hazard_ctrl_load_use_cmp.sv | 25 ++
 rtl/de_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_de_hazard_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/de_hazard_ctrl_pkg.sv
// Shared types and constants for the decode/execute hazard controller.
// Optional build macro: HAZ_PERF_CNT_EN (stall/flush performance counters).
package de_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } haz_state_e;

    localparam int HAZ_REG_AW = 3;
    localparam int FLASH_W    = 2;
    localparam int CNT_W      = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/de_hazard_ctrl_load_use_cmp.sv
// Load-use comparator: decode sources against a loading execute instruction.
// Shared with the forwarding unit; purely combinational.
module haz_load_use_cmp
    import de_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = HAZ_REG_AW
) (
    input  logic [REG_AW-1:0] src1_i,
    input  logic [REG_AW-1:0] src2_i,
    input  logic              uses_src1_i,
    input  logic              uses_src2_i,
    input  logic              ex_mr_i,
    input  logic              ex_rw_i,
    input  logic [REG_AW-1:0] ex_dst_i,
    output logic              load_use_o
);

    logic hit1;
    logic hit2;

    assign hit1 = uses_src1_i && (src1_i == ex_dst_i);
    assign hit2 = uses_src2_i && (src2_i == ex_dst_i);
    assign load_use_o = ex_mr_i && ex_rw_i && (hit1 || hit2);

endmodule

// File: rtl/de_hazard_ctrl.sv
// Hazard/flush controller: stall, bubble, fetch flush and FlashNum countdown.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module de_hazard_ctrl
    import de_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int REG_AW      = HAZ_REG_AW
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [REG_AW-1:0]  DecSrc1,
    input  logic [REG_AW-1:0]  DecSrc2,
    input  logic               DecUsesSrc1,
    input  logic               DecUsesSrc2,
    input  logic               ExMR,
    input  logic               ExRW,
    input  logic [REG_AW-1:0]  ExRegDst,
    input  logic               BranchTaken,
    input  logic               MemBusy,
    output logic               Stall,
    output logic               Bubble,
    output logic               FlushFD,
    output logic [FLASH_W-1:0] FlashNum,
    output logic [CNT_W-1:0]   StallCount,
    output logic [CNT_W-1:0]   FlushCount
);

    localparam logic [FLASH_W-1:0] FLASH_START = FLASH_W'(FLUSH_DEPTH - 1);
    localparam logic [FLASH_W-1:0] FLASH_ONE   = FLASH_W'(1);

    haz_state_e         state_q, state_d;
    logic [FLASH_W-1:0] flash_q, flash_d;
    logic               load_use;

    haz_load_use_cmp #(
        .REG_AW(REG_AW)
    ) u_load_use_cmp (
        .src1_i      (DecSrc1),
        .src2_i      (DecSrc2),
        .uses_src1_i (DecUsesSrc1),
        .uses_src2_i (DecUsesSrc2),
        .ex_mr_i     (ExMR),
        .ex_rw_i     (ExRW),
        .ex_dst_i    (ExRegDst),
        .load_use_o  (load_use)
    );

    // State and FlashNum registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_RUN;
            flash_q <= '0;
        end else begin
            state_q <= state_d;
            flash_q <= flash_d;
        end
    end

    assign FlashNum = flash_q;

    // Next-state and control decode; a HOLD exit cycle behaves like RUN
    always_comb begin
        state_d = state_q;
        flash_d = flash_q;
        Stall   = 1'b0;
        Bubble  = 1'b0;
        FlushFD = 1'b0;
        unique case (state_q)
            ST_FLUSH: begin
                Bubble  = 1'b1;
                FlushFD = 1'b1;
                if (MemBusy) begin
                    Stall = 1'b1;
                end else if (flash_q <= FLASH_ONE) begin
                    state_d = ST_RUN;
                    flash_d = '0;
                end else begin
                    flash_d = flash_q - 1'b1;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (state_q == ST_HOLD && MemBusy) begin
                    Stall = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    if (BranchTaken) begin
                        FlushFD = 1'b1;
                        Bubble  = 1'b1;
                        Stall   = MemBusy;
                        if (FLUSH_DEPTH > 1) begin
                            state_d = ST_FLUSH;
                            flash_d = FLASH_START;
                        end else begin
                            flash_d = '0;
                        end
                    end else if (MemBusy) begin
                        Stall   = 1'b1;
                        state_d = ST_HOLD;
                    end else if (load_use) begin
                        Stall  = 1'b1;
                        Bubble = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                flash_d = '0;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic             br_acc;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    assign br_acc = BranchTaken
                 && (state_q != ST_FLUSH)
                 && !(state_q == ST_HOLD && MemBusy);

    // Saturating counters of stalled cycles and accepted taken branches
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (Stall) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (br_acc) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_de_hazard_ctrl.sv
// Directed scoreboard bench for de_hazard_ctrl (FLUSH_DEPTH=2, REG_AW=3).
// Counter expectations follow HAZ_PERF_CNT_EN when it is defined.
module tb_de_hazard_ctrl;

    typedef struct {
        logic        st;
        logic        bu;
        logic        ff;
        logic [1:0]  fn;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [2:0]  DecSrc1 = '0;
    logic [2:0]  DecSrc2 = '0;
    logic        DecUsesSrc1 = 1'b0;
    logic        DecUsesSrc2 = 1'b0;
    logic        ExMR = 1'b0;
    logic        ExRW = 1'b0;
    logic [2:0]  ExRegDst = '0;
    logic        BranchTaken = 1'b0;
    logic        MemBusy = 1'b0;
    logic        Stall;
    logic        Bubble;
    logic        FlushFD;
    logic [1:0]  FlashNum;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          stepn = 0;
    logic [15:0] m_sc = '0;
    logic [15:0] m_fc = '0;

    always #5 Clk = ~Clk;

    de_hazard_ctrl #(
        .FLUSH_DEPTH(2),
        .REG_AW(3)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .DecSrc1(DecSrc1), .DecSrc2(DecSrc2),
        .DecUsesSrc1(DecUsesSrc1), .DecUsesSrc2(DecUsesSrc2),
        .ExMR(ExMR), .ExRW(ExRW), .ExRegDst(ExRegDst),
        .BranchTaken(BranchTaken), .MemBusy(MemBusy),
        .Stall(Stall), .Bubble(Bubble), .FlushFD(FlushFD),
        .FlashNum(FlashNum),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL step%0d %s observed %h expected %h", stepn, tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, push expectation, compare at the falling edge
    task automatic step(
        input logic rst, input logic bt, input logic mb,
        input logic mr, input logic rw, input logic [2:0] dst,
        input logic u1, input logic [2:0] s1,
        input logic u2, input logic [2:0] s2,
        input logic est, input logic ebu, input logic eff, input logic [1:0] efn
    );
        exp_t e;
        exp_t g;
        @(posedge Clk);
        #1;
        Rst = rst; BranchTaken = bt; MemBusy = mb;
        ExMR = mr; ExRW = rw; ExRegDst = dst;
        DecUsesSrc1 = u1; DecSrc1 = s1;
        DecUsesSrc2 = u2; DecSrc2 = s2;
        e.st = est; e.bu = ebu; e.ff = eff; e.fn = efn;
        e.sc = PERF ? m_sc : 16'h0;
        e.fc = PERF ? m_fc : 16'h0;
        sb.push_back(e);
        @(negedge Clk);
        stepn++;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL step%0d scoreboard observed empty expected entry", stepn);
        end else begin
            g = sb.pop_front();
            chk("Stall", {15'd0, Stall}, {15'd0, g.st});
            chk("Bubble", {15'd0, Bubble}, {15'd0, g.bu});
            chk("FlushFD", {15'd0, FlushFD}, {15'd0, g.ff});
            chk("FlashNum", {14'd0, FlashNum}, {14'd0, g.fn});
            chk("StallCount", StallCount, g.sc);
            chk("FlushCount", FlushCount, g.fc);
        end
        if (!rst) begin
            m_sc = '0;
            m_fc = '0;
        end else begin
            if (est && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (eff && efn == 2'd0 && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end
    endtask

    initial begin
        Rst = 1'b0;
        @(posedge Clk);
        // reset held, then idle
        step(0,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        // load-use on src1, then load gone
        step(1,0,0, 1,1,3'd3, 1,3'd3, 0,3'd0, 1,1,0,2'd0);
        step(1,0,0, 0,1,3'd3, 1,3'd3, 0,3'd0, 0,0,0,2'd0);
        // same registers but no source used
        step(1,0,0, 1,1,3'd3, 0,3'd3, 0,3'd3, 0,0,0,2'd0);
        // load-use on src2, then non-writing load
        step(1,0,0, 1,1,3'd5, 0,3'd1, 1,3'd5, 1,1,0,2'd0);
        step(1,0,0, 1,0,3'd5, 0,3'd1, 1,3'd5, 0,0,0,2'd0);
        // taken branch: FlashNum 0,1,0
        step(1,1,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd0);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd1);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        // branch with load-use: branch wins; FLUSH ignores both
        step(1,1,0, 1,1,3'd3, 1,3'd3, 0,3'd0, 0,1,1,2'd0);
        step(1,1,0, 1,1,3'd3, 1,3'd3, 0,3'd0, 0,1,1,2'd1);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        // MemBusy for 3 cycles mid-FLUSH
        step(1,1,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd0);
        step(1,0,1, 0,0,3'd0, 0,3'd0, 0,3'd0, 1,1,1,2'd1);
        step(1,0,1, 0,0,3'd0, 0,3'd0, 0,3'd0, 1,1,1,2'd1);
        step(1,0,1, 0,0,3'd0, 0,3'd0, 0,3'd0, 1,1,1,2'd1);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd1);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        // HOLD, exit cycle sees load-use
        step(1,0,1, 0,0,3'd0, 0,3'd0, 0,3'd0, 1,0,0,2'd0);
        step(1,0,1, 1,1,3'd2, 1,3'd2, 0,3'd0, 1,0,0,2'd0);
        step(1,0,0, 1,1,3'd2, 1,3'd2, 0,3'd0, 1,1,0,2'd0);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        // branch with MemBusy: flush registered, stall asserted
        step(1,1,1, 0,0,3'd0, 0,3'd0, 0,3'd0, 1,1,1,2'd0);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd1);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        // reset during HOLD with MemBusy
        step(1,0,1, 0,0,3'd0, 0,3'd0, 0,3'd0, 1,0,0,2'd0);
        step(0,0,1, 0,0,3'd0, 0,3'd0, 0,3'd0, 1,0,0,2'd0);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        // reset during FLUSH
        step(1,1,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd0);
        step(0,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd1);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        // HOLD exit cycle takes a branch
        step(1,0,1, 0,0,3'd0, 0,3'd0, 0,3'd0, 1,0,0,2'd0);
        step(1,1,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd0);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,1,1,2'd1);
        step(1,0,0, 0,0,3'd0, 0,3'd0, 0,3'd0, 0,0,0,2'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
